// File: rtl/pipe_step_pkg.sv
// rtl/pipe_step_pkg.sv - mode encodings and step FSM state type for pipe_step_ctrl
package pipe_step_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_DIV  = 2'b10;
  localparam logic [1:0] MODE_FULL = 2'b11;

  typedef enum logic [1:0] {
    ST_HALT,
    ST_ARMED,
    ST_RUN_DIV,
    ST_RUN_FULL
  } step_state_t;

  function automatic step_state_t mode_to_state(input logic [1:0] m);
    case (m)
      MODE_STEP: return ST_ARMED;
      MODE_DIV:  return ST_RUN_DIV;
      MODE_FULL: return ST_RUN_FULL;
      default:   return ST_HALT;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - one switch channel: 2-flop synchroniser, stability counter, edge pulses
module sw_debounce #(
  parameter int DB_CYCLES = 600000,
  parameter int DB_W      = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            cand;
  logic [DB_W-1:0] cnt;

  // Synchroniser runs through reset so sw_db can load the settled level.
  always_ff @(posedge clk) begin
    sync1 <= raw;
    sync2 <= sync1;
  end

  always_ff @(posedge clk) begin
    rise <= 1'b0;
    fall <= 1'b0;
    if (reset) begin
      cand <= sync2;
      db   <= sync2;
      cnt  <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt == CNT_MAX && cand != db) begin
      db   <= cand;
      cnt  <= '0;
      rise <= cand;
      fall <= ~cand;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + DB_W'(1);
    end
  end

endmodule

// File: rtl/pipe_step_ctrl.sv
// rtl/pipe_step_ctrl.sv - debounced switches and pipeline step_en generator (breakpoint: PIPE_STEP_BRK_EN)
module pipe_step_ctrl
  import pipe_step_pkg::*;
#(
  parameter int N_SW      = 4,
  parameter int DB_CYCLES = 600000,
  parameter int DB_W      = 21,
  parameter int STEP_CH   = 0,
  parameter int DIV_W     = 24,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] run_div,
  input  logic             reg_write,
  output logic [N_SW-1:0]  sw_db,
  output logic [N_SW-1:0]  sw_rise,
  output logic [N_SW-1:0]  sw_fall,
  output logic             step_en,
  output logic [CNT_W-1:0] step_cnt,
  output logic             led
`ifdef PIPE_STEP_BRK_EN
  ,
  input  logic [CNT_W-1:0] brk_cnt,
  input  logic             brk_arm,
  output logic             brk_hit
`endif
);

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (sw_raw[i]),
      .db   (sw_db[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

  step_state_t      state;
  step_state_t      next_state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] run_div_q;
  logic [DIV_W-1:0] period;
  logic             step_en_d;

`ifdef PIPE_STEP_BRK_EN
  logic brk_lock;
  logic brk_arm_q;
  logic brk_fire;
`endif

  // step_en is decided from the state being entered, so a mode change acts one cycle later.
  always_comb begin
    next_state = mode_to_state(mode);
`ifdef PIPE_STEP_BRK_EN
    if (brk_lock) next_state = ST_HALT;
`endif
    step_en_d = 1'b0;
    div_d     = '0;
    period    = (run_div == '0) ? DIV_W'(1) : run_div;
    case (next_state)
      ST_ARMED:    step_en_d = sw_rise[STEP_CH];
      ST_RUN_DIV: begin
        if (state == ST_RUN_DIV && run_div == run_div_q) begin
          if (div_q >= period - DIV_W'(1)) begin
            step_en_d = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      ST_RUN_FULL: step_en_d = 1'b1;
      default:     step_en_d = 1'b0;
    endcase
`ifdef PIPE_STEP_BRK_EN
    brk_fire = brk_arm && step_en_d &&
               (next_state == ST_RUN_DIV || next_state == ST_RUN_FULL) &&
               (step_cnt + CNT_W'(1) == brk_cnt);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HALT;
      step_en   <= 1'b0;
      step_cnt  <= '0;
      led       <= 1'b0;
      div_q     <= '0;
      run_div_q <= run_div;
    end else begin
      state     <= next_state;
      step_en   <= step_en_d;
      step_cnt  <= step_cnt + CNT_W'(step_en_d);
      led       <= led ^ (reg_write & step_en);
      div_q     <= div_d;
      run_div_q <= run_div;
    end
  end

`ifdef PIPE_STEP_BRK_EN
  // The lock holds HALT after a hit until software parks the mode at 00.
  always_ff @(posedge clk) begin
    if (reset) begin
      brk_hit   <= 1'b0;
      brk_lock  <= 1'b0;
      brk_arm_q <= 1'b0;
    end else begin
      brk_arm_q <= brk_arm;
      if (brk_fire) begin
        brk_hit  <= 1'b1;
        brk_lock <= 1'b1;
      end else begin
        if (mode == MODE_HALT) brk_lock <= 1'b0;
        if (brk_arm_q && !brk_arm) brk_hit <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// tb/tb_pipe_step_ctrl.sv - directed self-checking bench for pipe_step_ctrl
module tb_pipe_step_ctrl;

  localparam int N_SW      = 4;
  localparam int DB_CYCLES = 8;
  localparam int DB_W      = 4;
  localparam int STEP_CH   = 0;
  localparam int DIV_W     = 8;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SW-1:0]  sw_raw;
  logic [1:0]       mode;
  logic [DIV_W-1:0] run_div;
  logic             reg_write;
  logic [N_SW-1:0]  sw_db;
  logic [N_SW-1:0]  sw_rise;
  logic [N_SW-1:0]  sw_fall;
  logic             step_en;
  logic [CNT_W-1:0] step_cnt;
  logic             led;
`ifdef PIPE_STEP_BRK_EN
  logic [CNT_W-1:0] brk_cnt;
  logic             brk_arm;
  logic             brk_hit;
`endif

  int checks = 0;
  int errors = 0;

  pipe_step_ctrl #(
    .N_SW     (N_SW),
    .DB_CYCLES(DB_CYCLES),
    .DB_W     (DB_W),
    .STEP_CH  (STEP_CH),
    .DIV_W    (DIV_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .mode     (mode),
    .run_div  (run_div),
    .reg_write(reg_write),
    .sw_db    (sw_db),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .step_en  (step_en),
    .step_cnt (step_cnt),
    .led      (led)
`ifdef PIPE_STEP_BRK_EN
    ,
    .brk_cnt  (brk_cnt),
    .brk_arm  (brk_arm),
    .brk_hit  (brk_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int   n;
    int   last;
    int   toggles;
    logic prev_led;
    logic prev_rise;

    reset = 1'b1; sw_raw = '0; mode = 2'b00; run_div = 8'd4; reg_write = 1'b0;
`ifdef PIPE_STEP_BRK_EN
    brk_cnt = 16'd6; brk_arm = 1'b0;
`endif
    repeat (4) tick();
    check("reset_step_en", step_en, 0);
    check("reset_step_cnt", step_cnt, 0);
    check("reset_led", led, 0);
    check("reset_sw_db", sw_db, 0);
    reset = 1'b0;
    tick();

    // Debounce: first sampling edge + 10 edges before sw_db moves.
    sw_raw = 4'b0001;
    repeat (10) tick();
    check("db_before_accept", sw_db, 0);
    tick();
    check("db_accept_level", sw_db, 1);
    check("db_accept_rise", sw_rise, 1);
    tick();
    check("db_rise_one_cycle", sw_rise, 0);
    repeat (8) tick();
    n = 0;
    sw_raw = 4'b0000;
    repeat (5) begin tick(); n += int'(sw_fall[0]); end
    sw_raw = 4'b0001;
    repeat (15) begin tick(); n += int'(sw_fall[0]); end
    check("glitch_no_fall", n, 0);
    check("glitch_db_held", sw_db, 1);
    sw_raw = 4'b0000;
    repeat (14) tick();
    check("release_db", sw_db, 0);

    // Single-step: three clean presses.
    mode = 2'b01; prev_rise = 1'b0; n = 0;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 28; j++) begin
        sw_raw = (j < 14) ? 4'b0001 : 4'b0000;
        tick();
        check("step_follows_rise", step_en, prev_rise);
        n += int'(step_en);
        prev_rise = sw_rise[0];
      end
    end
    check("step_pulses", n, 3);
    check("step_cnt_after_step", step_cnt, 3);

    // Divided run, period 4.
    mode = 2'b00; run_div = 8'd4; tick();
    mode = 2'b10; tick();
    n = 0; last = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (step_en) begin
        n++;
        if (n == 1) check("div_first_pulse", i, 4);
        else check("div_spacing", i - last, 4);
        last = i;
      end
    end
    check("div_pulses", n, 10);
    mode = 2'b00; tick();
    check("div_stop", step_en, 0);
    run_div = 8'd0; mode = 2'b10; tick();
    check("div0_entry", step_en, 0);
    repeat (5) begin tick(); check("div0_every_cycle", step_en, 1); end
    mode = 2'b00; tick();
    check("div0_stop", step_en, 0);
    check("step_cnt_after_div", step_cnt, 18);

    // Full speed with reg_write: led follows advancing cycles only.
    reg_write = 1'b1; mode = 2'b11; toggles = 0; prev_led = led;
    repeat (5) begin
      tick();
      check("full_step_en", step_en, 1);
      toggles += int'(led != prev_led); prev_led = led;
    end
    mode = 2'b00;
    tick();
    check("full_stop", step_en, 0);
    toggles += int'(led != prev_led); prev_led = led;
    repeat (3) begin tick(); toggles += int'(led != prev_led); prev_led = led; end
    check("led_toggles", toggles, 5);
    check("step_cnt_after_full", step_cnt, 23);
    repeat (5) tick();
    check("led_halt_constant", led, 1);

    // Reset in the middle of a full-speed run with switches high.
    reg_write = 1'b0; mode = 2'b11; sw_raw = 4'b0011;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_step_en", step_en, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_led", led, 0);
    check("rst_sw_rise", sw_rise, 0);
    check("rst_sw_fall", sw_fall, 0);
    check("rst_sw_db", sw_db, 3);
    reset = 1'b0; mode = 2'b00; n = 0;
    repeat (12) begin tick(); n += int'(sw_rise != '0); end
    check("rst_no_rise", n, 0);
    check("rst_sw_db_kept", sw_db, 3);

`ifdef PIPE_STEP_BRK_EN
    brk_cnt = 16'd6; brk_arm = 1'b1; mode = 2'b11; n = 0;
    repeat (12) begin tick(); n += int'(step_en); end
    check("brk_pulses", n, 6);
    check("brk_hit_set", brk_hit, 1);
    check("brk_step_cnt", step_cnt, 6);
    mode = 2'b00; tick();
    mode = 2'b11; tick();
    check("brk_resume", step_en, 1);
    brk_arm = 1'b0; tick();
    check("brk_hit_clear", brk_hit, 0);
    mode = 2'b00; tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
